// File: rtl/uart_pkt_deframer.sv
// UART packet deframer: hunts for 0xA5 sync, validates LEN/payload/XOR checksum, replays payload.
// Optional inter-byte timeout when UART_PKT_TIMEOUT_EN is defined.
module uart_pkt_deframer #(
  parameter int unsigned MAX_LEN        = 64,
  parameter int unsigned TIMEOUT_CYCLES = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_framing_err,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       pkt_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned IDX_W = $clog2(MAX_LEN);
  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam logic [7:0]  SYNC  = 8'hA5;

  typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CSUM, S_DRAIN} state_t;

  state_t           state;
  logic [7:0]       len;
  logic [7:0]       csum;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] last_idx;
  logic [7:0]       buf_mem [DEPTH];
  logic             in_frame;
  logic             rx_ok;
  logic             rx_bad;
  logic             tmo_hit;

  assign last_idx = IDX_W'(len - 8'd1);
  assign in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
  assign rx_ok    = in_valid && !in_framing_err;
  assign rx_bad   = in_valid && in_framing_err;

`ifdef UART_PKT_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Idle-cycle counter; any received byte or leaving the framing states restarts it.
  always_ff @(posedge clk) begin
    if (rst || in_valid || !in_frame) tmo_cnt <= '0;
    else                              tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  assign tmo_hit = in_frame && !in_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  // Timeout disabled: framing states wait indefinitely for the next byte.
  assign tmo_hit = 1'b0;
  if (TIMEOUT_CYCLES == 0) begin : g_tmo_unused
  end
`endif

  // Payload buffer; contents are only meaningful between CSUM match and end of DRAIN.
  always_ff @(posedge clk) begin
    if (state == S_PAYLOAD && rx_ok) buf_mem[wr_idx] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_HUNT;
      len       <= '0;
      csum      <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      pkt_err   <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      pkt_err <= 1'b0;
      overrun <= 1'b0;
      if (in_frame && (rx_bad || tmo_hit)) begin
        pkt_err <= 1'b1;
        state   <= S_HUNT;
        busy    <= 1'b0;
      end else begin
        unique case (state)
          S_HUNT: begin
            if (rx_ok && in_data == SYNC) begin
              state <= S_LEN;
              busy  <= 1'b1;
              csum  <= '0;
            end
          end
          S_LEN: begin
            if (rx_ok) begin
              if (in_data == 8'd0 || in_data > 8'(MAX_LEN)) begin
                pkt_err <= 1'b1;
                state   <= S_HUNT;
                busy    <= 1'b0;
              end else begin
                len    <= in_data;
                csum   <= csum ^ in_data;
                wr_idx <= '0;
                state  <= S_PAYLOAD;
              end
            end
          end
          S_PAYLOAD: begin
            if (rx_ok) begin
              csum   <= csum ^ in_data;
              wr_idx <= wr_idx + IDX_W'(1);
              if (wr_idx == last_idx) state <= S_CSUM;
            end
          end
          S_CSUM: begin
            if (rx_ok) begin
              if ((csum ^ in_data) == 8'h00) begin
                state     <= S_DRAIN;
                out_valid <= 1'b1;
                out_data  <= buf_mem[0];
                out_last  <= (len == 8'd1);
                rd_idx    <= IDX_W'(1);
              end else begin
                pkt_err <= 1'b1;
                state   <= S_HUNT;
                busy    <= 1'b0;
              end
            end
          end
          S_DRAIN: begin
            // Upstream cannot be stalled, so bytes arriving now are lost.
            if (in_valid) overrun <= 1'b1;
            if (out_ready) begin
              if (out_last) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                state     <= S_HUNT;
                busy      <= 1'b0;
              end else begin
                out_data <= buf_mem[rd_idx];
                out_last <= (rd_idx == last_idx);
                rd_idx   <= rd_idx + IDX_W'(1);
              end
            end
          end
          default: begin
            state <= S_HUNT;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
